// File: rtl/except_ctrl_if.sv
// Commit-stage exception bus between the pipeline/CP0 side (master) and except_ctrl (slave).
interface except_ctrl_if;
  logic        stall_i;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [8:0]  mem_exc_i;
  logic [31:0] mem_data_vaddr_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic [31:0] excepttype_o;
  logic [31:0] pc_o;
  logic [31:0] bad_vaddr_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        new_pc_valid_o;
  logic        redirect_ack_i;
  logic        busy_o;

  modport master (
    output stall_i, mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_exc_i,
           mem_data_vaddr_i, status_i, cause_i, epc_i, redirect_ack_i,
    input  excepttype_o, pc_o, bad_vaddr_o, is_in_delayslot_o, flush_o,
           new_pc_o, new_pc_valid_o, busy_o
  );

  modport slave (
    input  stall_i, mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_exc_i,
           mem_data_vaddr_i, status_i, cause_i, epc_i, redirect_ack_i,
    output excepttype_o, pc_o, bad_vaddr_o, is_in_delayslot_o, flush_o,
           new_pc_o, new_pc_valid_o, busy_o
  );
endinterface

// File: rtl/except_ctrl.sv
// Commit-stage exception controller: prioritises interrupts/exceptions, flushes, redirects fetch.
// Optional macro EXC_TRAP_EN enables the trap flag (mem_exc_i[3]); otherwise it is ignored.
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input logic          clk,
  input logic          rst,
  except_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;

  state_t      state, state_nx;
  logic        int_pend_r;
  logic        int_pend_c;
  logic [8:0]  exc;
  logic        accept;
  logic [31:0] code_c, bad_c, new_pc_c;
  logic [31:0] code_r, pc_r, bad_r, new_pc_r;
  logic        ds_r;
  logic        unused_bits;

  assign unused_bits = ^{bus.status_i[31:16], bus.status_i[7:2],
                         bus.cause_i[31:16], bus.cause_i[7:0]};

  assign int_pend_c = bus.status_i[0] & ~bus.status_i[1] &
                      (|(bus.cause_i[15:8] & bus.status_i[15:8]));

  always_comb begin
    exc = bus.mem_exc_i;
`ifdef EXC_TRAP_EN
`else
    exc[3] = 1'b0;
`endif
  end

  assign accept = (state == IDLE) & bus.mem_valid_i & ~bus.stall_i &
                  (int_pend_r | (|exc));

  // Priority encode: interrupt first, eret last
  always_comb begin
    code_c   = 32'h0;
    bad_c    = 32'h0;
    new_pc_c = EXC_VECTOR;
    if (int_pend_r)  code_c = 32'h1;
    else if (exc[0]) begin code_c = 32'h4; bad_c = bus.mem_pc_i; end
    else if (exc[1]) code_c = 32'ha;
    else if (exc[2]) code_c = 32'hc;
    else if (exc[3]) code_c = 32'hd;
    else if (exc[4]) code_c = 32'h8;
    else if (exc[5]) code_c = 32'h9;
    else if (exc[6]) begin code_c = 32'h4; bad_c = bus.mem_data_vaddr_i; end
    else if (exc[7]) begin code_c = 32'h5; bad_c = bus.mem_data_vaddr_i; end
    else if (exc[8]) begin code_c = 32'he; new_pc_c = bus.epc_i; end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      int_pend_r <= 1'b0;
      code_r     <= 32'h0;
      pc_r       <= 32'h0;
      bad_r      <= 32'h0;
      ds_r       <= 1'b0;
      new_pc_r   <= 32'h0;
    end else begin
      state      <= state_nx;
      int_pend_r <= accept ? 1'b0 : int_pend_c;
      if (accept) begin
        code_r   <= code_c;
        pc_r     <= bus.mem_pc_i;
        bad_r    <= bad_c;
        ds_r     <= bus.mem_in_delayslot_i;
        new_pc_r <= new_pc_c;
      end
    end
  end

  always_comb begin
    state_nx           = state;
    bus.excepttype_o   = 32'h0;
    bus.flush_o        = 1'b0;
    bus.new_pc_valid_o = 1'b0;
    bus.busy_o         = 1'b1;
    case (state)
      IDLE: begin
        bus.busy_o = 1'b0;
        if (accept) state_nx = COMMIT;
      end
      COMMIT: begin
        bus.excepttype_o = code_r;
        bus.flush_o      = 1'b1;
        state_nx         = REDIRECT;
      end
      REDIRECT: begin
        bus.new_pc_valid_o = 1'b1;
        if (bus.redirect_ack_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.pc_o              = pc_r;
  assign bus.bad_vaddr_o       = bad_r;
  assign bus.is_in_delayslot_o = ds_r;
  assign bus.new_pc_o          = new_pc_r;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed self-checking bench for except_ctrl; inputs driven 1 time unit after each rising edge.
module tb_except_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  except_ctrl_if bus();

  except_ctrl #(.EXC_VECTOR(32'hBFC00380)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.stall_i            = 1'b0;
    bus.mem_valid_i        = 1'b0;
    bus.mem_pc_i           = 32'h0;
    bus.mem_in_delayslot_i = 1'b0;
    bus.mem_exc_i          = 9'h0;
    bus.mem_data_vaddr_i   = 32'h0;
    bus.redirect_ack_i     = 1'b0;
  endtask

  task automatic present(input logic [8:0] exc, input logic [31:0] pc,
                         input logic [31:0] vaddr, input logic ds);
    bus.mem_valid_i        = 1'b1;
    bus.mem_exc_i          = exc;
    bus.mem_pc_i           = pc;
    bus.mem_data_vaddr_i   = vaddr;
    bus.mem_in_delayslot_i = ds;
  endtask

  task automatic finish_redirect(input string tag, input logic [31:0] exp_pc);
    tick();
    check({tag, "_nvalid"}, 32'(bus.new_pc_valid_o), 32'h1);
    check({tag, "_newpc"}, bus.new_pc_o, exp_pc);
    bus.redirect_ack_i = 1'b1;
    tick();
    bus.redirect_ack_i = 1'b0;
    check({tag, "_idle"}, 32'(bus.busy_o), 32'h0);
  endtask

  initial begin
    idle_inputs();
    bus.status_i = 32'h0;
    bus.cause_i  = 32'h0;
    bus.epc_i    = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy_o), 32'h0);
    check("rst_exctype", bus.excepttype_o, 32'h0);
    check("rst_flush", 32'(bus.flush_o), 32'h0);
    check("rst_nvalid", 32'(bus.new_pc_valid_o), 32'h0);
    check("rst_newpc", bus.new_pc_o, 32'h0);
    check("rst_pc", bus.pc_o, 32'h0);

    // Syscall, ack held off one extra cycle
    present(9'h010, 32'h80001000, 32'h0, 1'b0);
    tick();
    idle_inputs();
    check("sys_busy", 32'(bus.busy_o), 32'h1);
    check("sys_exctype", bus.excepttype_o, 32'h8);
    check("sys_flush", 32'(bus.flush_o), 32'h1);
    check("sys_pc", bus.pc_o, 32'h80001000);
    check("sys_bad", bus.bad_vaddr_o, 32'h0);
    tick();
    check("sys_exctype_off", bus.excepttype_o, 32'h0);
    check("sys_flush_off", 32'(bus.flush_o), 32'h0);
    check("sys_nvalid0", 32'(bus.new_pc_valid_o), 32'h1);
    finish_redirect("sys", 32'hBFC00380);

    // Invalid instruction with flags, plus stray ack, must not start anything
    present(9'h010, 32'h80001004, 32'h0, 1'b0);
    bus.mem_valid_i    = 1'b0;
    bus.redirect_ack_i = 1'b1;
    tick();
    check("novalid_busy", 32'(bus.busy_o), 32'h0);
    tick();
    check("novalid_busy2", 32'(bus.busy_o), 32'h0);
    idle_inputs();

    // Interrupt beats RI
    bus.status_i = 32'h0000FF01;
    bus.cause_i  = 32'h00000400;
    tick();
    present(9'h002, 32'h80001100, 32'h0, 1'b0);
    tick();
    idle_inputs();
    bus.status_i = 32'h0;
    bus.cause_i  = 32'h0;
    check("int_exctype", bus.excepttype_o, 32'h1);
    finish_redirect("int", 32'hBFC00380);

    // Ov beats syscall
    present(9'h014, 32'h80001200, 32'h0, 1'b0);
    tick();
    idle_inputs();
    check("ov_exctype", bus.excepttype_o, 32'hc);
    finish_redirect("ov", 32'hBFC00380);

    // Data AdEL in a delay slot
    present(9'h040, 32'h80002000, 32'h80002003, 1'b1);
    tick();
    idle_inputs();
    check("dadel_exctype", bus.excepttype_o, 32'h4);
    check("dadel_bad", bus.bad_vaddr_o, 32'h80002003);
    check("dadel_ds", 32'(bus.is_in_delayslot_o), 32'h1);
    finish_redirect("dadel", 32'hBFC00380);

    // Fetch AdEL beats AdES; bad address is the PC
    present(9'h081, 32'h80004004, 32'h80005000, 1'b0);
    tick();
    idle_inputs();
    check("fadel_exctype", bus.excepttype_o, 32'h4);
    check("fadel_bad", bus.bad_vaddr_o, 32'h80004004);
    check("fadel_ds", 32'(bus.is_in_delayslot_o), 32'h0);
    finish_redirect("fadel", 32'hBFC00380);

    // Eret: EPC sampled at acceptance, ack after 5 redirect cycles
    bus.epc_i = 32'h80003000;
    present(9'h100, 32'h80002100, 32'h0, 1'b0);
    tick();
    idle_inputs();
    bus.epc_i = 32'h12345678;
    check("eret_exctype", bus.excepttype_o, 32'he);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("eret_nvalid", 32'(bus.new_pc_valid_o), 32'h1);
      check("eret_newpc", bus.new_pc_o, 32'h80003000);
      if (i == 4) bus.redirect_ack_i = 1'b1;
      tick();
    end
    bus.redirect_ack_i = 1'b0;
    check("eret_nvalid_off", 32'(bus.new_pc_valid_o), 32'h0);
    check("eret_idle", 32'(bus.busy_o), 32'h0);

    // Stall holds off acceptance, then reset in REDIRECT
    present(9'h010, 32'h80006000, 32'h0, 1'b0);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_busy", 32'(bus.busy_o), 32'h0);
    end
    bus.stall_i = 1'b0;
    tick();
    idle_inputs();
    check("stall_exctype", bus.excepttype_o, 32'h8);
    check("stall_pc", bus.pc_o, 32'h80006000);
    tick();
    check("stall_nvalid", 32'(bus.new_pc_valid_o), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_busy", 32'(bus.busy_o), 32'h0);
    check("rst2_nvalid", 32'(bus.new_pc_valid_o), 32'h0);
    check("rst2_newpc", bus.new_pc_o, 32'h0);
    check("rst2_pc", bus.pc_o, 32'h0);
    check("rst2_exctype", bus.excepttype_o, 32'h0);

    // Trap flag alone
    present(9'h008, 32'h80007000, 32'h0, 1'b0);
    tick();
    idle_inputs();
`ifdef EXC_TRAP_EN
    check("trap_exctype", bus.excepttype_o, 32'hd);
    check("trap_busy", 32'(bus.busy_o), 32'h1);
    finish_redirect("trap", 32'hBFC00380);
`else
    check("trap_busy", 32'(bus.busy_o), 32'h0);
    check("trap_exctype", bus.excepttype_o, 32'h0);
    tick();
    check("trap_busy2", 32'(bus.busy_o), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
